// File: rtl/accumulator_control_decoder_if.sv
// accumulator_control_decoder_if: opcode/flag inputs and control outputs between decoder and datapath
// master: decoder side (reads op_code and Z/N flags, drives every control line)
// slave: datapath side (drives op_code and flags, consumes controls)
interface accumulator_control_decoder_if #(
  parameter int DATA_WIDTH = 11,
  parameter int INSTRUCTION_WIDTH = 16
);
  logic [INSTRUCTION_WIDTH-DATA_WIDTH-1:0] op_code;
  logic status_Z_in;
  logic status_N_in;
  logic branch_out;
  logic [1:0] sel_A_out;
  logic sel_B_out;
  logic alu_op_out;
  logic data_memory_wr_out;
  logic acc_wr_out;
  logic pc_wr_out;
  logic status_wr_out;
  logic ir_wr_out;
  logic acc_reset_out;
  logic pc_reset_out;
  logic status_reset_out;
  logic ir_reset_out;
  modport master (
    input  op_code, status_Z_in, status_N_in,
    output branch_out, sel_A_out, sel_B_out, alu_op_out, data_memory_wr_out,
           acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out,
           acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out
  );
  modport slave (
    output op_code, status_Z_in, status_N_in,
    input  branch_out, sel_A_out, sel_B_out, alu_op_out, data_memory_wr_out,
           acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out,
           acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out
  );
endinterface

// File: rtl/accumulator_control_decoder.sv
// accumulator_control_decoder: two-phase fetch/execute control unit for the 16-bit accumulator CPU
// clock_in: rising-edge clock; reset_in: asynchronous active-low reset
// bus (master): op_code and Z/N flags in; selects, write enables, branch and register clears out
module accumulator_control_decoder #(
  parameter int DATA_WIDTH = 11,
  parameter int INSTRUCTION_WIDTH = 16
) (
  input logic clock_in,
  input logic reset_in,
  accumulator_control_decoder_if.master bus
);
  localparam int OW = INSTRUCTION_WIDTH - DATA_WIDTH;
  typedef enum logic [1:0] {RST, FETCH, EXEC} state_t;
  state_t state_q, state_d;
  logic [OW-1:0] op;
  logic ex, arith, br_op, cond;
  assign op = bus.op_code;
  always_comb state_d = state_q == FETCH ? EXEC : FETCH;
  always_ff @(posedge clock_in or negedge reset_in)
    if (!reset_in) state_q <= RST;
    else state_q <= state_d;
  // Outputs stay combinational so a flag change or reset shows up within the same cycle.
  always_comb begin
    ex = state_q == EXEC;
    arith = op >= OW'(4) && op <= OW'(7);
    br_op = op >= OW'(8) && op <= OW'(14);
    cond = op[2:0] == 3'd0 ? bus.status_Z_in :
           op[2:0] == 3'd1 ? !bus.status_Z_in :
           op[2:0] == 3'd2 ? !bus.status_Z_in && !bus.status_N_in :
           op[2:0] == 3'd3 ? !bus.status_N_in :
           op[2:0] == 3'd4 ? bus.status_N_in :
           op[2:0] == 3'd5 ? bus.status_Z_in || bus.status_N_in : 1'b1;
    bus.acc_reset_out = state_q == RST;
    bus.pc_reset_out = state_q == RST;
    bus.status_reset_out = state_q == RST;
    bus.ir_reset_out = state_q == RST;
    bus.ir_wr_out = state_q == FETCH;
    bus.pc_wr_out = ex && op != '0;
    bus.data_memory_wr_out = ex && op == OW'(1);
    bus.acc_wr_out = ex && (op == OW'(2) || op == OW'(3) || arith);
    bus.status_wr_out = ex && arith;
    bus.sel_A_out = !ex ? 2'b00 : arith ? 2'b10 : op == OW'(3) ? 2'b01 : 2'b00;
    bus.sel_B_out = ex && arith && op[0];
    bus.alu_op_out = ex && arith && op[1];
    bus.branch_out = ex && br_op && cond;
  end
endmodule

// File: tb/tb_accumulator_control_decoder.sv
// tb_accumulator_control_decoder: scoreboard bench with random and directed instruction streams
module tb_accumulator_control_decoder;
  logic clk = 1'b0;
  logic reset_in = 1'b0;
  int errors = 0;
  int checks = 0;
  int ph = 0;
  logic [13:0] exp_q[$];
  event mid_ev;
  accumulator_control_decoder_if #(.DATA_WIDTH(11), .INSTRUCTION_WIDTH(16)) bus ();
  accumulator_control_decoder #(.DATA_WIDTH(11), .INSTRUCTION_WIDTH(16)) dut (
    .clock_in(clk),
    .reset_in(reset_in),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [13:0] model(int p, logic [4:0] op, logic z, logic n);
    logic br, sb, alu, dm, acc, pc, st, ir, rs;
    logic [1:0] sa;
    int o;
    {br, sb, alu, dm, acc, pc, st, ir, rs, sa} = '0;
    o = int'(op);
    if (p == 0) rs = 1;
    else if (p == 1) ir = 1;
    else if (o == 0) begin end
    else if (o == 1) begin dm = 1; pc = 1; end
    else if (o == 2) begin acc = 1; pc = 1; end
    else if (o == 3) begin sa = 2'b01; acc = 1; pc = 1; end
    else if (o <= 7) begin
      sa = 2'b10; acc = 1; st = 1; pc = 1;
      sb = (o == 5 || o == 7);
      alu = (o >= 6);
    end else if (o <= 14) begin
      pc = 1;
      case (o)
        8: br = z;
        9: br = !z;
        10: br = !z && !n;
        11: br = !n;
        12: br = n;
        13: br = z || n;
        default: br = 1;
      endcase
    end else pc = 1;
    return {br, sa, sb, alu, dm, acc, pc, st, ir, rs, rs, rs, rs};
  endfunction
  function automatic logic [13:0] actual();
    return {bus.branch_out, bus.sel_A_out, bus.sel_B_out, bus.alu_op_out, bus.data_memory_wr_out,
            bus.acc_wr_out, bus.pc_wr_out, bus.status_wr_out, bus.ir_wr_out,
            bus.acc_reset_out, bus.pc_reset_out, bus.status_reset_out, bus.ir_reset_out};
  endfunction
  // Phase numbering: 0 reset, 1 fetch, 2 execute.
  task automatic step(input logic [4:0] op, input logic z, input logic n);
    @(posedge clk);
    ph = !reset_in ? 0 : (ph == 1 ? 2 : 1);
    #1;
    bus.op_code = op;
    bus.status_Z_in = z;
    bus.status_N_in = n;
    exp_q.push_back(model(ph, op, z, n));
  endtask
  task automatic instr(input logic [4:0] op, input logic z, input logic n);
    step(op, z, n);
    step(op, z, n);
  endtask
  task automatic mid_flags(input logic z, input logic n);
    @(negedge clk);
    #3;
    bus.status_Z_in = z;
    bus.status_N_in = n;
    exp_q.push_back(model(ph, bus.op_code, z, n));
    -> mid_ev;
  endtask
  initial begin
    logic [13:0] e, a;
    forever begin
      @(negedge clk or negedge reset_in or mid_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL ctrl_vec op=%b Z=%b N=%b got=%b want=%b t=%0t",
                   bus.op_code, bus.status_Z_in, bus.status_N_in, a, e, $time);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [1:0] fl [4];
    fl[0] = 2'b00; fl[1] = 2'b10; fl[2] = 2'b11; fl[3] = 2'b01;
    bus.op_code = 5'd4;
    bus.status_Z_in = 0;
    bus.status_N_in = 0;
    for (int i = 0; i < 3; i++) step(5'($urandom), 1'($urandom), 1'($urandom));
    reset_in = 1'b1;
    for (int op = 4; op <= 7; op++) instr(5'(op), 1'($urandom), 1'($urandom));
    for (int op = 1; op <= 3; op++) instr(5'(op), 1'($urandom), 1'($urandom));
    for (int op = 8; op <= 14; op++)
      for (int f = 0; f < 4; f++) instr(5'(op), fl[f][1], fl[f][0]);
    instr(5'd8, 1'b0, 1'b0);
    mid_flags(1'b1, 1'b0);
    instr(5'd12, 1'b0, 1'b0);
    mid_flags(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) instr(5'd0, 1'($urandom), 1'($urandom));
    instr(5'b10101, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) instr(5'($urandom), 1'($urandom), 1'($urandom));
    instr(5'd4, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    reset_in = 1'b0;
    ph = 0;
    exp_q.push_back(model(0, bus.op_code, bus.status_Z_in, bus.status_N_in));
    step(5'd4, 1'b0, 1'b0);
    reset_in = 1'b1;
    instr(5'd6, 1'b1, 1'b0);
    instr(5'd14, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/accumulator_control_decoder.md
Name: accumulator_control_decoder

Overview:
- Control unit for the 16-bit accumulator CPU: instruction = 5-bit opcode + 11-bit operand.
- Two-phase FSM. FETCH latches the instruction register. EXECUTE decodes the opcode and the Z/N status flags into datapath select, write-enable and branch controls.
- Also generates the datapath register resets.
- Purely control; no datapath storage.

Parameters:
- DATA_WIDTH, 11, operand/immediate field width.
- INSTRUCTION_WIDTH, 16, instruction width; opcode width = INSTRUCTION_WIDTH - DATA_WIDTH (5).

Ports:
- clock_in  input  1  system clock; all state changes on the rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- op_code  input  INSTRUCTION_WIDTH-DATA_WIDTH  opcode field from the IR.
- status_Z_in  input  1  zero flag from the status register.
- status_N_in  input  1  negative flag from the status register.
- branch_out  output  1  1 = PC loads the operand (branch target); 0 = PC+1.
- sel_A_out  output  2  accumulator source: 00 = data memory, 01 = immediate operand, 10 = ALU result, 11 = reserved (datapath treats it as 00).
- sel_B_out  output  1  ALU B operand: 0 = data memory, 1 = immediate.
- alu_op_out  output  1  0 = add, 1 = subtract.
- data_memory_wr_out  output  1  data memory write enable (stores ACC).
- acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out  output  1 each  register write enables.
- acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out  output  1 each  active-high synchronous clears for the datapath registers.

Behaviour:
- States: RST, FETCH, EXEC.
- reset_in = 0 forces RST immediately (asynchronous), regardless of clock.
- In RST:
  - all four *_reset_out = 1;
  - every write enable, branch_out, sel_B_out and alu_op_out = 0;
  - sel_A_out = 00.
- Transitions:
  - RST -> FETCH on the first rising edge with reset_in = 1.
  - FETCH -> EXEC, unconditionally.
  - EXEC -> FETCH, unconditionally.
  - Each instruction therefore takes 2 cycles.
- Outputs are Moore/combinational functions of the state, op_code and flags. In FETCH and EXEC all *_reset_out = 0.
- FETCH: ir_wr_out = 1; all other enables = 0; branch_out = 0.
- EXEC: ir_wr_out = 0. Listed signals = 1; unlisted enables, branch_out, sel_B_out and alu_op_out = 0; sel_A_out = 00 unless given.
  - 00000 HLT: no enables. PC is not written, so the same instruction is re-fetched forever (halt until reset).
  - 00001 STO: data_memory_wr, pc_wr.
  - 00010 LD: sel_A=00, acc_wr, pc_wr.
  - 00011 LDI: sel_A=01, acc_wr, pc_wr.
  - 00100 ADD: sel_A=10, sel_B=0, alu_op=0, acc_wr, status_wr, pc_wr.
  - 00101 ADDI: as ADD with sel_B=1.
  - 00110 SUB: as ADD with alu_op=1.
  - 00111 SUBI: sel_B=1, alu_op=1, otherwise as ADD.
  - 01000 to 01110 (branches/jump): pc_wr = 1 always. branch_out = 1 when the condition is true, else 0 (PC+1). No acc/status/memory writes.
    - BEQ: Z.
    - BNE: !Z.
    - BGT: !Z & !N.
    - BGE: !N.
    - BLT: N.
    - BLE: Z | N.
    - JMP: 1.
  - 01111 to 11111 (undefined): NOP; pc_wr only.
- Flags are sampled combinationally during EXEC; a flag change mid-EXEC updates branch_out in the same cycle.
- Reset asserted mid-instruction aborts it; outputs go to RST values without waiting for an edge.

Test Plan:
- Reset: reset_in=0 with any op_code.
  - Expect all *_reset_out=1, all enables=0, sel_A=00.
  - Release: next edge -> FETCH (ir_wr=1, resets=0); following edge -> EXEC.
- Arithmetic sweep: in EXEC, apply 00100/00101/00110/00111.
  - Expect sel_A=10, acc_wr=status_wr=pc_wr=1.
  - sel_B/alu_op respectively 0/0, 1/0, 0/1, 1/1.
- Memory ops in EXEC:
  - STO (00001) -> data_memory_wr=1, acc_wr=0.
  - LD (00010) -> sel_A=00, acc_wr=1.
  - LDI (00011) -> sel_A=01, acc_wr=1.
- Branch truth table: for each of 01000 to 01101, sweep {Z,N} over 00, 10, 11, 01.
  - Expect branch_out per the condition table, e.g. BGT gives 1 only at Z=0,N=0; BLE gives 1 for 10, 11, 01.
  - pc_wr=1 throughout; JMP (01110) gives branch_out=1 for all flag combinations.
- HLT: op_code=00000 over several instructions.
  - Expect EXEC pc_wr=0, all enables 0.
  - FETCH still alternates with EXEC (ir_wr pulses every 2nd cycle).
- Undefined opcode 10101 in EXEC -> only pc_wr=1.
- Async reset mid-EXEC of ADD -> outputs switch to RST values before the next clock edge.
